// File: rtl/music_pkg.sv
// Shared types and score-word layout for the melody sequencer and its score ROM.
package music_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_t;

    localparam int CODE_MSB = 11;
    localparam int CODE_LSB = 4;
    localparam int DUR_MSB  = 3;
    localparam int DUR_LSB  = 0;

    localparam logic [7:0] REST_CODE = 8'h00;
    localparam logic [3:0] END_DUR   = 4'd0;

    function automatic logic is_rest(input logic [7:0] note);
        return note == REST_CODE;
    endfunction

endpackage

// File: rtl/score_rom.sv
// Synchronous score ROM with a registered read port; contents are built in.
module score_rom
  import music_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              iclk,
  input  logic [ADDR_W-1:0] addr,
  output logic [11:0]       data
);

  logic [11:0] mem [2**ADDR_W];

  function automatic logic [11:0] score_word(input int idx);
    case (idx)
      0:       return {8'h04, 4'd2};
      1:       return {8'h06, 4'd2};
      2:       return {8'h08, 4'd2};
      3:       return {REST_CODE, 4'd1};
      4:       return {8'h09, 4'd2};
      5:       return {8'h0B, 4'd2};
      6:       return {8'h0D, 4'd4};
      default: return {REST_CODE, END_DUR};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i] = score_word(i);
    end
  end

  always_ff @(posedge iclk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/melody_sequencer.sv
// Walks the score ROM, timing each note in beat ticks and muting the speaker
// for rests, pauses and the articulation gap at the end of every note.
module melody_sequencer
    import music_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int BEAT_HZ = 8,
    parameter int ADDR_W  = 8,
    parameter int GAP_CYC = 2500000
) (
    input  logic              iclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [7:0]        code,
    output logic              mute,
    output logic              busy,
    output logic              done
);

    localparam int TICK_CYC = CLK_HZ / BEAT_HZ;
    localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    // Last PLAY tick of the final beat; the next tick value starts the gap.
    localparam logic [TICK_W-1:0] GAP_FROM  = TICK_W'(TICK_CYC - GAP_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [3:0]        dur_cnt;
    logic              rest;

    logic [7:0] word_code;
    logic [3:0] word_dur;
    logic       end_reached;

    assign word_code = rom_data[CODE_MSB:CODE_LSB];
    assign word_dur  = rom_data[DUR_MSB:DUR_LSB];

    // The last ROM slot finishing behaves exactly like reading an end marker.
    assign end_reached = ((state == LOAD) && (word_dur == END_DUR)) ||
                         ((state == GAP) && !pause && (tick == TICK_LAST) &&
                          (rom_addr == ADDR_LAST));

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            code     <= '0;
            mute     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            tick     <= '0;
            dur_cnt  <= '0;
            rest     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                rom_addr <= '0;
                code     <= '0;
                mute     <= 1'b1;
                busy     <= 1'b0;
                tick     <= '0;
                dur_cnt  <= '0;
            end else if (start) begin
                state    <= FETCH;
                rom_addr <= '0;
                mute     <= 1'b1;
                busy     <= 1'b1;
                tick     <= '0;
                dur_cnt  <= '0;
            end else if (end_reached) begin
                tick    <= '0;
                dur_cnt <= '0;
                mute    <= 1'b1;
                if (loop_en) begin
                    rom_addr <= '0;
                    state    <= FETCH;
                end else begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    code  <= '0;
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: ;
                    FETCH: state <= LOAD;
                    LOAD: begin
                        code    <= word_code;
                        dur_cnt <= word_dur;
                        tick    <= '0;
                        rest    <= is_rest(word_code);
                        mute    <= is_rest(word_code);
                        state   <= PLAY;
                    end
                    PLAY: begin
                        if (pause) begin
                            mute <= 1'b1;
                        end else if ((dur_cnt == 4'd1) && (tick == GAP_FROM)) begin
                            tick  <= tick + 1'b1;
                            mute  <= 1'b1;
                            state <= GAP;
                        end else begin
                            mute <= rest;
                            if (tick == TICK_LAST) begin
                                tick    <= '0;
                                dur_cnt <= dur_cnt - 4'd1;
                            end else begin
                                tick <= tick + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (!pause) begin
                            if (tick == TICK_LAST) begin
                                tick     <= '0;
                                dur_cnt  <= '0;
                                rom_addr <= rom_addr + 1'b1;
                                state    <= FETCH;
                            end else begin
                                tick <= tick + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed and randomized bench for melody_sequencer against a note-timeline model.
module tb_melody_sequencer;

    localparam int CLK_HZ  = 100;
    localparam int BEAT_HZ = 10;
    localparam int ADDR_W  = 8;
    localparam int GAP_CYC = 2;
    localparam int T       = CLK_HZ / BEAT_HZ;
    localparam int LEN     = 2 ** ADDR_W;

    logic              iclk;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [7:0]        code;
    logic              mute;
    logic              busy;
    logic              done;

    logic [11:0] rom [LEN];

    int n_cmp;
    int n_err;

    // Reference model: phase 0 idle, 1 fetch, 2 load, 3 sounding note.
    int       m_phase;
    int       m_addr;
    int       m_elapsed;
    int       m_len;
    logic     m_rest;
    logic [7:0] m_code;
    logic     m_mute;
    logic     m_busy;
    logic     m_done;

    int unm [256];
    int done_pulses;
    int busy_cyc;

    melody_sequencer #(
        .CLK_HZ (CLK_HZ),
        .BEAT_HZ(BEAT_HZ),
        .ADDR_W (ADDR_W),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .iclk    (iclk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .loop_en (loop_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .code    (code),
        .mute    (mute),
        .busy    (busy),
        .done    (done)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(posedge iclk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_addr    = 0;
        m_elapsed = 0;
        m_len     = 0;
        m_rest    = 1'b0;
        m_code    = 8'h00;
        m_mute    = 1'b1;
        m_busy    = 1'b0;
        m_done    = 1'b0;
    endtask

    task automatic model_song_end();
        if (loop_en) begin
            m_addr  = 0;
            m_phase = 1;
        end else begin
            m_done  = 1'b1;
            m_busy  = 1'b0;
            m_code  = 8'h00;
            m_phase = 0;
        end
        m_mute = 1'b1;
    endtask

    task automatic model_edge();
        logic [11:0] w;
        m_done = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (stop) begin
            m_phase = 0;
            m_addr  = 0;
            m_code  = 8'h00;
            m_mute  = 1'b1;
            m_busy  = 1'b0;
        end else if (start) begin
            m_phase = 1;
            m_addr  = 0;
            m_mute  = 1'b1;
            m_busy  = 1'b1;
        end else begin
            case (m_phase)
                1: m_phase = 2;
                2: begin
                    w = rom[m_addr];
                    if (w[3:0] == 4'd0) begin
                        model_song_end();
                    end else begin
                        m_code    = w[11:4];
                        m_rest    = (w[11:4] == 8'h00);
                        m_len     = int'(w[3:0]) * T;
                        m_elapsed = 0;
                        m_mute    = m_rest;
                        m_phase   = 3;
                    end
                end
                3: begin
                    if (pause) begin
                        m_mute = 1'b1;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == m_len) begin
                            m_mute = 1'b1;
                            if (m_addr == LEN - 1) begin
                                model_song_end();
                            end else begin
                                m_addr++;
                                m_phase = 1;
                            end
                        end else begin
                            m_mute = m_rest || (m_elapsed >= m_len - GAP_CYC);
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("code", 32'(code), 32'(m_code));
        chk("mute", 32'(mute), 32'(m_mute));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge iclk);
        #1;
        check_outputs();
        if (!mute) unm[code]++;
        if (done) done_pulses++;
        if (busy) busy_cyc++;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 256; i++) unm[i] = 0;
        done_pulses = 0;
        busy_cyc    = 0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < LEN; i++) rom[i] = 12'h000;
    endtask

    task automatic load_score_a();
        clear_rom();
        rom[0] = 12'h042;
        rom[1] = 12'h001;
        rom[2] = 12'h153;
        rom[3] = 12'h000;
    endtask

    task automatic run_until_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            cycle();
            if (!busy && m_phase == 0) break;
        end
        chk("song_finished_busy", 32'(busy), 32'd0);
    endtask

    task automatic go();
        start = 1'b1;
        cycle();
    endtask

    initial begin
        int first_code;
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        loop_en = 1'b0;
        clear_rom();
        clear_stats();
        model_reset();

        // Reset state
        repeat (3) cycle();
        #2;
        rst_n = 1'b1;
        cycle();

        // Score A, single pass
        load_score_a();
        clear_stats();
        go();
        run_until_idle(200);
        chk("note04_unmuted", 32'(unm[8'h04]), 32'd18);
        chk("note15_unmuted", 32'(unm[8'h15]), 32'd28);
        chk("rest_unmuted", 32'(unm[8'h00]), 32'd0);
        chk("done_once", 32'(done_pulses), 32'd1);
        chk("busy_span", 32'(busy_cyc), 32'd68);
        repeat (3) cycle();

        // Score A, looping
        clear_stats();
        loop_en = 1'b1;
        go();
        repeat (150) cycle();
        chk("loop_no_done", 32'(done_pulses), 32'd0);
        chk("loop_note04_twice", 32'(unm[8'h04] >= 36), 32'd1);
        stop = 1'b1;
        cycle();
        loop_en = 1'b0;
        repeat (2) cycle();

        // Pause held for 7 cycles inside note 0x04
        clear_stats();
        go();
        repeat (6) cycle();
        pause = 1'b1;
        repeat (7) cycle();
        pause = 1'b0;
        run_until_idle(200);
        chk("pause_note04_unmuted", 32'(unm[8'h04]), 32'd18);
        chk("pause_busy_span", 32'(busy_cyc), 32'd75);
        repeat (2) cycle();

        // Restart during the third note, then stop and start together
        go();
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (code == 8'h15) break;
        end
        chk("third_note_reached", 32'(code), 32'h15);
        repeat (5) cycle();
        start = 1'b1;
        cycle();
        first_code = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!mute) begin
                first_code = int'(code);
                break;
            end
        end
        chk("restart_first_note", 32'(first_code), 32'h04);
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        chk("stopstart_busy", 32'(busy), 32'd0);
        chk("stopstart_code", 32'(code), 32'd0);
        chk("stopstart_mute", 32'(mute), 32'd1);
        repeat (2) cycle();

        // Full ROM of one-beat notes: must end without address wrap
        for (int i = 0; i < LEN; i++) rom[i] = {8'($urandom_range(255)), 4'd1};
        clear_stats();
        go();
        run_until_idle(LEN * (T + 2) + 20);
        chk("full_rom_done", 32'(done_pulses), 32'd1);
        chk("full_rom_addr_held", 32'(rom_addr), 32'd255);
        repeat (2) cycle();

        // Asynchronous reset in the middle of a note
        go();
        repeat (25) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mute", 32'(mute), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_code", 32'(code), 32'd0);
        chk("async_rst_addr", 32'(rom_addr), 32'd0);
        model_reset();
        repeat (2) cycle();
        #2;
        rst_n = 1'b1;
        cycle();

        // Randomized songs with random pauses, loop mode and occasional restarts
        for (int s = 0; s < 8; s++) begin
            int notes;
            clear_rom();
            notes = $urandom_range(5, 1);
            for (int i = 0; i < notes; i++) begin
                logic [7:0] c;
                c = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
                rom[i] = {c, 4'($urandom_range(6, 1))};
            end
            loop_en = 1'($urandom_range(1));
            pause   = 1'b0;
            go();
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(15) == 0) pause = ~pause;
                if ($urandom_range(299) == 0) start = 1'b1;
                if ($urandom_range(499) == 0) stop = 1'b1;
                cycle();
                if (!busy && m_phase == 0) break;
            end
            pause = 1'b0;
            stop  = 1'b1;
            cycle();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
